// File: rtl/axis_trans_pipe.sv
// Two-stage axis fold: pass / negate / abs / reflect about PIVOT,
// with saturation to W bits and a sticking saturation counter.
module axis_trans_pipe #(
    parameter int                    M     = 4,
    parameter int                    N     = 8,
    parameter logic signed [M+N-1:0] PIVOT = '0,
    parameter int                    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   out_data,
    output logic             out_sign,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);
    localparam int W = M + N;
    localparam logic signed [W:0] MAXV = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MINV = {2'b11, {(W-1){1'b0}}};

    logic             r_s1_valid;
    logic signed [W:0] r_d;
    logic [1:0]       r_mode;
    logic             r_neg;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic             r_out_sign;
    logic             r_out_sat;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_en;
    logic             w_s1_en;
    logic signed [W:0] w_x;
    logic signed [W:0] w_p;
    logic signed [W:0] w_d;
    logic signed [W:0] w_r;
    logic             w_fold;
    logic             w_hi;
    logic             w_lo;
    logic [W-1:0]     w_res;
    logic             w_inc;

    assign w_s2_en  = !r_out_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en && rst_n;

    // One extra bit keeps -MIN and x-PIVOT exact before clamping.
    assign w_x = {in_data[W-1], in_data};
    assign w_p = {PIVOT[W-1], PIVOT};

    always_comb begin
        w_d = w_x;
        case (in_mode)
            2'd1:    w_d = -w_x;
            2'd3:    w_d = w_x - w_p;
            default: w_d = w_x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_d        <= '0;
            r_mode     <= 2'd0;
            r_neg      <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_d    <= w_d;
                r_mode <= in_mode;
                r_neg  <= w_d[W];
            end
        end
    end

    assign w_fold = r_mode[1] && r_neg;
    assign w_r    = w_fold ? -r_d : r_d;
    assign w_hi   = w_r > MAXV;
    assign w_lo   = w_r < MINV;

    always_comb begin
        w_res = w_r[W-1:0];
        if (w_hi)
            w_res = MAXV[W-1:0];
        else if (w_lo)
            w_res = MINV[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sign  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_sign <= w_fold;
                r_out_sat  <= w_hi || w_lo;
            end
        end
    end

    assign w_inc = r_out_valid && out_ready && r_out_sat;

    // Clear beats a coincident increment; the count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (cnt_clr)
            r_cnt <= '0;
        else if (w_inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sign  = r_out_sign;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_cnt;
endmodule

// File: tb/tb_axis_trans_pipe.sv
// Directed bench for axis_trans_pipe: mode sweep, saturation,
// backpressure, mid-stream reset and saturation counter edges.
module tb_axis_trans_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [11:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [11:0] out_data, out_data2;
    logic        out_sign, out_sign2;
    logic        out_sat, out_sat2;
    logic [15:0] sat_cnt;
    logic [1:0]  sat_cnt2;
    logic        cnt_clr;

    logic        bp;
    logic        r_fix;
    logic        r_rand;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          inflight = 0;
    logic [13:0] exp_q[$];

    // {mode, data, sign, sat, expected data}
    logic [27:0] sweep [4];
    logic [27:0] satv  [3];
    logic [27:0] tbl   [10];

    always #5 clk = ~clk;

    assign out_ready = bp ? r_rand : r_fix;

    axis_trans_pipe #(.M(4), .N(8), .PIVOT(12'h100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sign(out_sign), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    axis_trans_pipe #(.M(4), .N(8), .PIVOT(12'h100), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_sign(out_sign2), .out_sat(out_sat2),
        .sat_cnt(sat_cnt2), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [27:0] v);
        int   t;
        logic took;
        t = 0;
        took = 1'b0;
        exp_q.push_back(v[13:0]);
        in_valid = 1'b1;
        in_mode  = v[27:26];
        in_data  = v[25:14];
        while (!took && t < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!took)
            chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_mode  = ~v[27:26];
        in_data  = ~v[25:14];
    endtask

    task automatic send_lat(input logic [27:0] v);
        send(v);
        chk("lat_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (inflight != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", inflight, 0);
        chk("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        r_rand = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            r_rand = ($urandom_range(0, 9) < 3);
        end
    end

    // Scoreboard, hold-stability and in_ready model, sampled mid-cycle.
    initial begin
        logic        stall;
        logic [14:0] held;
        logic [13:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                inflight = 0;
                stall = 1'b0;
            end else begin
                if (stall)
                    chk("hold", {out_valid, out_sign, out_sat, out_data}, held);
                chk("in_ready", {in_ready, in_ready2},
                    (inflight == 2 && !out_ready) ? 0 : 3);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {out_sign, out_sat, out_data}, e);
                        chk("beat2", {out_valid2, out_sign2, out_sat2, out_data2},
                            {1'b1, e});
                    end
                end
                stall = out_valid && !out_ready;
                held  = {out_valid, out_sign, out_sat, out_data};
                inflight = inflight + int'(in_valid && in_ready)
                                    - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] c2 [4];
        int         t;
        sweep[0] = {2'd0, 12'h280, 2'b00, 12'h280};
        sweep[1] = {2'd1, 12'h280, 2'b00, 12'hD80};
        sweep[2] = {2'd2, 12'hF00, 2'b10, 12'h100};
        sweep[3] = {2'd3, 12'h080, 2'b10, 12'h080};
        satv[0]  = {2'd1, 12'h800, 2'b01, 12'h7FF};
        satv[1]  = {2'd2, 12'h800, 2'b11, 12'h7FF};
        satv[2]  = {2'd3, 12'h800, 2'b11, 12'h7FF};
        tbl[0]   = {2'd0, 12'h123, 2'b00, 12'h123};
        tbl[1]   = {2'd1, 12'h001, 2'b00, 12'hFFF};
        tbl[2]   = {2'd2, 12'h7FF, 2'b00, 12'h7FF};
        tbl[3]   = {2'd3, 12'h100, 2'b00, 12'h000};
        tbl[4]   = {2'd3, 12'h0FF, 2'b10, 12'h001};
        tbl[5]   = {2'd1, 12'h800, 2'b01, 12'h7FF};
        tbl[6]   = {2'd2, 12'hFFF, 2'b10, 12'h001};
        tbl[7]   = {2'd0, 12'h800, 2'b00, 12'h800};
        tbl[8]   = {2'd3, 12'h7FF, 2'b00, 12'h6FF};
        tbl[9]   = {2'd1, 12'h7FF, 2'b00, 12'h801};
        c2[0] = 2'd1;
        c2[1] = 2'd2;
        c2[2] = 2'd3;
        c2[3] = 2'd3;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 2'd0;
        in_data  = '0;
        cnt_clr  = 1'b0;
        bp       = 1'b0;
        r_fix    = 1'b1;

        #22;
        chk("rst_outs", {out_valid, out_sign, out_sat, out_data}, 0);
        chk("rst_cnt", sat_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++)
            send_lat(sweep[i]);
        drain();

        for (int i = 0; i < 3; i++)
            send_lat(satv[i]);
        drain();
        chk("sat_cnt3", sat_cnt, 3);
        chk("sat_cnt3_w2", sat_cnt2, 3);

        r_fix = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        chk("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {out_valid, out_sign, out_sat, out_data}, 0);
        chk("mid_rst_cnt", sat_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_cnt", sat_cnt, 0);
        r_fix = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_stale", out_valid, 0);
        end

        bp = 1'b1;
        for (int i = 0; i < 10; i++)
            send(tbl[i]);
        drain();
        bp = 1'b0;

        for (int i = 9; i >= 0; i--)
            send(tbl[i]);
        drain();
        repeat (4) begin
            in_mode = in_mode + 2'd1;
            @(posedge clk);
            #1;
            chk("idle_mode", out_valid, 0);
        end

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr", sat_cnt, 0);
        chk("clr_w2", sat_cnt2, 0);
        for (int i = 0; i < 4; i++) begin
            send(satv[0]);
            drain();
            chk("cnt_w2_step", sat_cnt2, c2[i]);
            chk("cnt_step", sat_cnt, i + 1);
        end

        r_fix = 1'b0;
        send(satv[0]);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("park_valid", out_valid, 1);
        cnt_clr = 1'b1;
        r_fix   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_wins", sat_cnt, 0);
        chk("clr_wins_w2", sat_cnt2, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
